// File: rtl/burst_pkg.sv
// Shared types and constants for the stream burst packer: FSM state encoding,
// overflow counter width and a saturating-increment helper.
package burst_pkg;

  typedef enum logic {
    S_LATENCY = 1'b0,
    S_FILL    = 1'b1
  } burst_state_e;

  localparam int OVF_CNT_W = 16;

  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
    return (v == {OVF_CNT_W{1'b1}}) ? v : v + OVF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/burst_fill_bank.sv
// Fill bank: M slots of CHANNELS x PRECISION samples, one indexed write port and
// a flat parallel read of every slot. Contents are not reset.
module burst_fill_bank #(
  parameter int M         = 5,
  parameter int CHANNELS  = 2,
  parameter int PRECISION = 5,
  localparam int IDX_W    = $clog2(M)
) (
  input  logic                                       clk,
  input  logic                                       we,
  input  logic [IDX_W-1:0]                           idx,
  input  logic [CHANNELS-1:0][PRECISION-1:0]         wdata,
  output logic [M-1:0][CHANNELS-1:0][PRECISION-1:0]  rd_data
);

  logic [M-1:0][CHANNELS-1:0][PRECISION-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[idx] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q;

endmodule

// File: rtl/stream_burst_packer.sv
// Packs M accepted samples into a double-buffered output burst after discarding
// INITIAL_LATENCY samples. Define BURST_PACKER_OVF_COUNT_EN to build the dropped-burst counter.
module stream_burst_packer
  import burst_pkg::*;
#(
  parameter int INITIAL_LATENCY = 3,
  parameter int M               = 5,
  parameter int PRECISION       = 5,
  parameter int CHANNELS        = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       ce,
  input  logic                                       in_valid,
  input  logic [CHANNELS-1:0][PRECISION-1:0]         data_in,
  output logic [M-1:0][CHANNELS-1:0][PRECISION-1:0]  data_out,
  output logic                                       out_valid,
  input  logic                                       out_ack,
  output logic                                       overflow,
  output logic [OVF_CNT_W-1:0]                       ovf_count
);

  localparam int IDX_W = $clog2(M);
  localparam int LAT_W = (INITIAL_LATENCY > 1) ? $clog2(INITIAL_LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((INITIAL_LATENCY > 0) ? INITIAL_LATENCY - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(M - 1);
  localparam burst_state_e RESET_STATE = (INITIAL_LATENCY == 0) ? S_FILL : S_LATENCY;

  burst_state_e state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
  logic out_valid_q, out_valid_d;
  logic overflow_q, overflow_d;
  logic [M-1:0][CHANNELS-1:0][PRECISION-1:0] data_out_q, data_out_d;
  logic [M-1:0][CHANNELS-1:0][PRECISION-1:0] bank_rd, burst_full;
  logic accept, bank_we, drop_burst;

  assign accept = ce & in_valid;

  burst_fill_bank #(
    .M(M), .CHANNELS(CHANNELS), .PRECISION(PRECISION)
  ) u_fill_bank (
    .clk     (clk),
    .we      (bank_we),
    .idx     (fill_idx_q),
    .wdata   (data_in),
    .rd_data (bank_rd)
  );

  // Output handshake: a burst is presented while out_valid=1 and held stable;
  // it is consumed on any edge where out_valid=1 and out_ack=1 (ce plays no part).
  // A burst completing on that same edge replaces it directly.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    fill_idx_d  = fill_idx_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    overflow_d  = overflow_q;
    bank_we     = 1'b0;
    drop_burst  = 1'b0;
    burst_full  = bank_rd;
    burst_full[M-1] = data_in;

    if (out_valid_q && out_ack) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      case (state_q)
        S_LATENCY: begin
          if (lat_cnt_q == LAT_LAST) begin
            state_d   = S_FILL;
            lat_cnt_d = '0;
          end else begin
            lat_cnt_d = lat_cnt_q + LAT_W'(1);
          end
        end
        S_FILL: begin
          bank_we = 1'b1;
          if (fill_idx_q == IDX_LAST) begin
            fill_idx_d = '0;
            if (!out_valid_q || out_ack) begin
              data_out_d  = burst_full;
              out_valid_d = 1'b1;
            end else begin
              drop_burst = 1'b1;
              overflow_d = 1'b1;
            end
          end else begin
            fill_idx_d = fill_idx_q + IDX_W'(1);
          end
        end
        default: state_d = RESET_STATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      lat_cnt_q   <= '0;
      fill_idx_q  <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      fill_idx_q  <= fill_idx_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef BURST_PACKER_OVF_COUNT_EN
  logic [OVF_CNT_W-1:0] ovf_count_q, ovf_count_d;

  always_comb begin
    ovf_count_d = ovf_count_q;
    if (drop_burst) begin
      ovf_count_d = sat_inc(ovf_count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count_q <= '0;
    end else begin
      ovf_count_q <= ovf_count_d;
    end
  end

  assign ovf_count = ovf_count_q;
`else
  assign ovf_count = '0;
`endif

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/stream_burst_packer.md
STREAM_BURST_PACKER -- requirements
Module: stream_burst_packer

Interface
REQ-001 Parameter INITIAL_LATENCY, default 3: number of accepted input samples discarded after reset (0 allowed).
REQ-002 Parameter M, default 5: samples per burst, M >= 2.
REQ-003 Parameter PRECISION, default 5: bits per channel sample.
REQ-004 Parameter CHANNELS, default 2: parallel channels per input sample, CHANNELS >= 1.
REQ-005 One clock; reset is synchronous and active-high. Ports are named clk and rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 ce  input  1  clock enable for the input side.
REQ-009 in_valid  input  1  data_in carries a sample this cycle.
REQ-010 data_in  input  [CHANNELS-1:0][PRECISION-1:0]  one sample per channel.
REQ-011 data_out  output  [M-1:0][CHANNELS-1:0][PRECISION-1:0]  completed burst; index 0 holds the oldest sample.
REQ-012 out_valid  output  1  data_out holds an unacknowledged burst.
REQ-013 out_ack  input  1  consumer takes data_out when out_valid=1.
REQ-014 overflow  output  1  sticky: at least one burst was dropped.
REQ-015 ovf_count  output  16  number of dropped bursts (see Configuration).

Function
REQ-016 A sample is accepted at a rising edge when ce=1, in_valid=1 and rst=0; a sample is never accepted otherwise.
REQ-017 FSM states: S_LATENCY, S_FILL. Reset enters S_LATENCY, or S_FILL directly when INITIAL_LATENCY=0.
REQ-018 In S_LATENCY, accepted samples are discarded; after INITIAL_LATENCY accepted samples the FSM moves to S_FILL, and the next accepted sample is burst index 0.
REQ-019 In S_FILL, an accepted sample is written to fill-bank slot fill_idx, and fill_idx increments, wrapping from M-1 to 0.
REQ-020 On the edge accepting slot M-1: if out_valid=0, or out_valid=1 with out_ack=1, the full burst (including this sample) loads data_out and out_valid=1 from the next cycle. This gives 1-cycle latency from the last sample.
REQ-021 On the edge accepting slot M-1 with out_valid=1 and out_ack=0, the new burst is dropped, data_out is unchanged, overflow sets, and ovf_count increments, saturating at 16'hFFFF.
REQ-022 out_ack=1 with out_valid=1 and no completing burst on that edge: out_valid=0 next cycle.
REQ-023 out_ack while out_valid=0 is ignored.
REQ-024 The handshake (out_valid, out_ack) is independent of ce; ce=0 freezes only acceptance, the FSM and the counters.
REQ-025 data_out is stable whenever out_valid=1 until the acknowledging edge.
REQ-026 Filling continues during back-pressure; the fill bank is a separate storage from data_out (double buffering).

Reset
REQ-027 The following are reset: FSM, latency counter, fill_idx=0, out_valid=0, data_out=0, overflow=0, ovf_count=0.
REQ-028 rst mid-burst discards the partial burst and any pending output, and restarts the latency phase. The fill-bank contents need no reset.

Configuration
REQ-029 Macro BURST_PACKER_OVF_COUNT_EN defined: ovf_count is implemented as in REQ-021.
REQ-030 Macro not defined: ovf_count is tied to 0 and no counter logic exists; overflow behaves identically in both cases.

Structure
REQ-031 Package burst_pkg holds the FSM state enum (S_LATENCY, S_FILL) and the OVF_CNT_W=16 constant.
REQ-032 Sub-module burst_fill_bank: an M x CHANNELS x PRECISION register array with write-enable and index inputs and a flat parallel read port. It is instantiated once.

Verification
REQ-033 Defaults, ce=1, out_ack=1, inputs 1,2,3 then 10..14 (both channels equal) -> first three samples dropped; out_valid one cycle after 14; data_out = {10,11,12,13,14}, index 0 = 10.
REQ-034 Back-to-back bursts 20..24 and 14,12,25,23,14 with out_ack held 1 -> two out_valid bursts with exact contents; overflow=0.
REQ-035 out_ack=0 across completion of bursts 10..14 and then 20..24 -> data_out stays {10..14}; overflow=1; ovf_count=1 (macro on) / 0 (macro off).
REQ-036 ce=0 or in_valid=0 on alternate cycles while streaming 4,1,7,3,2 -> burst {4,1,7,3,2}; gaps are not captured.
REQ-037 rst asserted after 3 samples of a burst -> out_valid=0; the next 3 accepted samples are dropped; the following 5 form the burst.
REQ-038 INITIAL_LATENCY=0, M=2, CHANNELS=1 -> the first two samples form the first burst.
